// File: rtl/conv_encoder_stream.sv
// Streaming convolutional encoder. Takes a frame of information bits over a
// valid/ready handshake, emits one coded symbol per bit, then K-1 zero tail
// symbols so the trellis ends in state 0. One-entry output register with
// full backpressure.
module conv_encoder_stream #(
    parameter int unsigned MAX_K       = 9,
    parameter int unsigned MAX_RATE    = 3,
    parameter int unsigned FRAME_LEN_W = 8
) (
    input  logic                               sys_clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               i_code_rate,
    input  logic [1:0]                         i_constr_len,
    input  logic [MAX_RATE-1:0][MAX_K-1:0]     i_gen_poly,
    input  logic [FRAME_LEN_W-1:0]             i_frame_len,
    input  logic                               i_start,
    input  logic                               i_bit_valid,
    input  logic                               i_bit,
    output logic                               o_bit_ready,
    output logic                               o_sym_valid,
    output logic [MAX_RATE-1:0]                o_sym,
    input  logic                               i_sym_ready,
    output logic                               o_busy,
    output logic                               o_done
);

    typedef enum logic [1:0] {StIdle, StData, StTail, StDone} state_e;

    state_e                           state_q, state_d;
    logic [MAX_K-2:0]                 hist_q, hist_d;
    logic                             rate_q, rate_d;
    logic [1:0]                       k_q, k_d;
    logic [MAX_RATE-1:0][MAX_K-1:0]   poly_q, poly_d;
    logic [FRAME_LEN_W-1:0]           len_q, len_d;
    logic [FRAME_LEN_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]                       tail_cnt_q, tail_cnt_d;
    logic [MAX_RATE-1:0]              sym_q, sym_d;
    logic                             sym_valid_q, sym_valid_d;
    logic                             done_q, done_d;

    logic                             step_ok;
    logic                             step;
    logic                             in_bit;
    logic [3:0]                       k_val;
    logic [3:0]                       tail_last;
    logic [MAX_K-1:0]                 win_mask;
    logic [MAX_K-1:0]                 window;
    logic [MAX_RATE-1:0]              sym_calc;

    // K = 3,5,7,9 from the 2-bit code; last tail index is K-2
    assign k_val     = {1'b0, k_q, 1'b1} + 4'd2;
    assign tail_last = {1'b0, k_q, 1'b1};
    assign win_mask  = ~({MAX_K{1'b1}} << k_val);

    // Tail steps feed zeros into the window
    assign in_bit = (state_q == StData) ? i_bit : 1'b0;
    assign window = {hist_q, in_bit};

    // A step may load the symbol register when it is empty or being drained
    assign step_ok = en && (!sym_valid_q || i_sym_ready);

    // Parity of the masked window per generator; poly 2 only at rate 1/3
    always_comb begin
        sym_calc = '0;
        for (int j = 0; j < MAX_RATE; j++) begin
            if (j < 2 || (j == 2 && rate_q)) begin
                sym_calc[j] = ^(window & poly_q[j] & win_mask);
            end
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        rate_d      = rate_q;
        k_d         = k_q;
        poly_d      = poly_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        done_d      = 1'b0;
        step        = 1'b0;
        o_bit_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start && i_frame_len != '0) begin
                    rate_d     = i_code_rate;
                    k_d        = i_constr_len;
                    poly_d     = i_gen_poly;
                    len_d      = i_frame_len;
                    hist_d     = '0;
                    bit_cnt_d  = '0;
                    tail_cnt_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                o_bit_ready = step_ok;
                if (i_bit_valid && step_ok) begin
                    step = 1'b1;
                    if (bit_cnt_q == len_q - 1'b1) begin
                        tail_cnt_d = '0;
                        state_d    = StTail;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StTail: begin
                if (step_ok) begin
                    step = 1'b1;
                    if (tail_cnt_q == tail_last) begin
                        state_d = StDone;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                // Hold until the final symbol has been taken downstream
                if (!sym_valid_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (step) begin
            hist_d = {hist_q[MAX_K-3:0], in_bit};
        end
    end

    // Symbol register: reload on a step, otherwise drain on acceptance
    always_comb begin
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        if (step) begin
            sym_d       = sym_calc;
            sym_valid_d = 1'b1;
        end else if (i_sym_ready) begin
            sym_valid_d = 1'b0;
        end
    end

    // State registers; en low freezes everything
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            hist_q      <= '0;
            rate_q      <= 1'b0;
            k_q         <= '0;
            poly_q      <= '0;
            len_q       <= '0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            rate_q      <= rate_d;
            k_q         <= k_d;
            poly_q      <= poly_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
        end
    end

    assign o_sym       = sym_q;
    assign o_sym_valid = sym_valid_q;
    assign o_done      = done_q;
    assign o_busy      = (state_q == StData) || (state_q == StTail);

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Bench for conv_encoder_stream: expected symbols are queued when a frame is
// set up; a negedge monitor pops and compares every accepted symbol.
module tb_conv_encoder_stream;

    logic             sys_clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b1;
    logic             i_code_rate = 1'b0;
    logic [1:0]       i_constr_len = 2'b00;
    logic [2:0][8:0]  i_gen_poly = '0;
    logic [7:0]       i_frame_len = '0;
    logic             i_start = 1'b0;
    logic             i_bit_valid = 1'b0;
    logic             i_bit = 1'b0;
    logic             o_bit_ready;
    logic             o_sym_valid;
    logic [2:0]       o_sym;
    logic             i_sym_ready = 1'b1;
    logic             o_busy;
    logic             o_done;

    int               checks = 0;
    int               errors = 0;
    int               done_cnt = 0;
    int               mode = 0;
    int               cyc = 0;
    logic [2:0]       sb[$];
    bit               frame_bits[256];
    logic [2:0][8:0]  poly_v;

    bit               prev_en_low = 1'b0;
    logic [2:0]       prev_sym;
    logic             prev_valid;

    conv_encoder_stream #(
        .MAX_K      (9),
        .MAX_RATE   (3),
        .FRAME_LEN_W(8)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .en          (en),
        .i_code_rate (i_code_rate),
        .i_constr_len(i_constr_len),
        .i_gen_poly  (i_gen_poly),
        .i_frame_len (i_frame_len),
        .i_start     (i_start),
        .i_bit_valid (i_bit_valid),
        .i_bit       (i_bit),
        .o_bit_ready (o_bit_ready),
        .o_sym_valid (o_sym_valid),
        .o_sym       (o_sym),
        .i_sym_ready (i_sym_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready / enable patterns, changed just after each rising edge
    always @(posedge sys_clk) begin
        #1;
        cyc++;
        case (mode)
            1: begin
                i_sym_ready = 1'($urandom % 2);
                en          = (($urandom % 6) != 0);
            end
            2: begin
                case (cyc % 4)
                    0: i_sym_ready = 1'b1;
                    1: i_sym_ready = 1'b0;
                    2: i_sym_ready = 1'b0;
                    default: i_sym_ready = 1'b1;
                endcase
                en = 1'b1;
            end
            3: begin
                i_sym_ready = 1'($urandom % 2);
                en          = 1'b1;
            end
            default: begin
                i_sym_ready = 1'b1;
                en          = 1'b1;
            end
        endcase
    end

    // Monitor: scoreboard pop on accepted symbols plus handshake invariants
    always @(negedge sys_clk) begin
        if (!rst) begin
            prev_en_low = 1'b0;
        end else begin
            if (o_done && en) done_cnt++;
            if (!o_busy) check("bit_ready_when_not_busy", 32'(o_bit_ready), 32'd0);
            if (o_sym_valid && !i_sym_ready)
                check("bit_ready_under_backpressure", 32'(o_bit_ready), 32'd0);
            if (!en) check("bit_ready_en_low", 32'(o_bit_ready), 32'd0);
            if (prev_en_low) begin
                check("sym_hold_en_low", 32'(o_sym), 32'(prev_sym));
                check("valid_hold_en_low", 32'(o_sym_valid), 32'(prev_valid));
            end
            prev_en_low = !en;
            prev_sym    = o_sym;
            prev_valid  = o_sym_valid;
            if (o_sym_valid && i_sym_ready && en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_symbol: got %0h expected none", o_sym);
                end else begin
                    check("symbol", 32'(o_sym), 32'(sb.pop_front()));
                end
            end
        end
    end

    // Reference: symbol t is the parity of each generator against the last K
    // inputs of the zero-padded input sequence
    task automatic model_push(input bit rate, input bit [1:0] kl, input logic [2:0][8:0] poly,
                              input int len);
        int k;
        int total;
        int inp[$];
        logic [2:0] s;
        k = 2 * int'(kl) + 3;
        total = len + k - 1;
        for (int t = 0; t < total; t++) inp.push_back((t < len) ? int'(frame_bits[t]) : 0);
        for (int t = 0; t < total; t++) begin
            s = '0;
            for (int j = 0; j < (rate ? 3 : 2); j++) begin
                int p;
                p = 0;
                for (int i = 0; i < k; i++)
                    if (t - i >= 0) p = p ^ (inp[t - i] & int'(poly[j][i]));
                s[j] = p[0];
            end
            sb.push_back(s);
        end
    endtask

    task automatic set_cfg(input bit rate, input bit [1:0] kl, input logic [2:0][8:0] poly,
                           input int len);
        i_code_rate  = rate;
        i_constr_len = kl;
        i_gen_poly   = poly;
        i_frame_len  = 8'(len);
    endtask

    task automatic start_frame(input bit mid_start);
        bit ok;
        ok = 1'b0;
        i_start = 1'b1;
        for (int g = 0; g < 50; g++) begin
            @(posedge sys_clk);
            #2;
            if (o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("busy_after_start", 32'(ok), 32'd1);
        i_start = mid_start;
        // Later config changes must not affect the running frame
        i_gen_poly   = {9'($urandom), 9'($urandom), 9'($urandom)};
        i_frame_len  = 8'($urandom);
        i_code_rate  = 1'($urandom);
        i_constr_len = 2'($urandom);
    endtask

    task automatic feed_bits(input int n);
        int  idx;
        int  guard;
        bit  hs;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 3000) begin
            if ($urandom % 4 == 0) begin
                i_bit_valid = 1'b0;
                i_bit       = 1'($urandom);
            end else begin
                i_bit_valid = 1'b1;
                i_bit       = frame_bits[idx];
            end
            @(negedge sys_clk);
            hs = i_bit_valid && o_bit_ready;
            @(posedge sys_clk);
            #2;
            if (hs) idx++;
            guard++;
        end
        i_bit_valid = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: got %0d bits expected %0d", idx, n);
        end
    endtask

    task automatic wait_done(input int d0);
        for (int g = 0; g < 2000; g++) begin
            @(posedge sys_clk);
            #2;
            if (done_cnt != d0) break;
        end
        repeat (3) @(posedge sys_clk);
        #2;
        check("done_pulses", 32'(done_cnt), 32'(d0 + 1));
        check("queue_drained", 32'(sb.size()), 32'd0);
        check("busy_after_frame", 32'(o_busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_sym", 32'(o_sym), 32'd0);
        check("rst_sym_valid", 32'(o_sym_valid), 32'd0);
        check("rst_bit_ready", 32'(o_bit_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
    endtask

    task automatic push_frame_a();
        sb.push_back(3'b011);
        sb.push_back(3'b001);
        sb.push_back(3'b000);
        sb.push_back(3'b010);
        sb.push_back(3'b010);
        sb.push_back(3'b011);
    endtask

    task automatic run_frame_a(input int m, input bit mid_start);
        int d0;
        mode = m;
        frame_bits[0] = 1'b1;
        frame_bits[1] = 1'b0;
        frame_bits[2] = 1'b1;
        frame_bits[3] = 1'b1;
        poly_v = '0;
        poly_v[0] = 9'b111;
        poly_v[1] = 9'b101;
        set_cfg(1'b0, 2'b00, poly_v, 4);
        push_frame_a();
        d0 = done_cnt;
        start_frame(mid_start);
        feed_bits(4);
        i_start = 1'b0;
        wait_done(d0);
    endtask

    initial begin
        int d0;
        int len;
        bit rate;
        bit [1:0] kl;

        #3;
        check_reset_outputs();
        @(posedge sys_clk);
        #1;
        rst = 1'b1;
        @(posedge sys_clk);
        #2;

        // Directed frame, always-ready then with a 1,0,0,1 ready pattern
        run_frame_a(0, 1'b0);
        run_frame_a(2, 1'b1);

        // Rate 1/3, K=3, one bit
        mode = 0;
        frame_bits[0] = 1'b1;
        poly_v = '0;
        poly_v[0] = 9'b111;
        poly_v[1] = 9'b101;
        poly_v[2] = 9'b011;
        set_cfg(1'b1, 2'b00, poly_v, 1);
        model_push(1'b1, 2'b00, poly_v, 1);
        d0 = done_cnt;
        start_frame(1'b0);
        feed_bits(1);
        wait_done(d0);

        // K=9, one bit 1: symbol t is just tap t of each generator
        mode = 3;
        poly_v = {9'($urandom), 9'($urandom), 9'($urandom)};
        frame_bits[0] = 1'b1;
        set_cfg(1'b0, 2'b11, poly_v, 1);
        for (int t = 0; t < 9; t++) sb.push_back({1'b0, poly_v[1][t], poly_v[0][t]});
        d0 = done_cnt;
        start_frame(1'b0);
        feed_bits(1);
        wait_done(d0);

        // Zero-length frame: start ignored, stray bits ignored
        mode = 0;
        @(posedge sys_clk);
        #2;
        d0 = done_cnt;
        set_cfg(1'b0, 2'b00, poly_v, 0);
        i_start = 1'b1;
        i_bit_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            i_bit = 1'($urandom);
            @(posedge sys_clk);
            #2;
            check("len0_busy", 32'(o_busy), 32'd0);
            check("len0_sym_valid", 32'(o_sym_valid), 32'd0);
        end
        i_start = 1'b0;
        i_bit_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2;
        check("len0_no_done", 32'(done_cnt), 32'(d0));

        // Reset after the second bit of a four-bit frame
        frame_bits[0] = 1'b1;
        frame_bits[1] = 1'b0;
        frame_bits[2] = 1'b1;
        frame_bits[3] = 1'b1;
        poly_v = '0;
        poly_v[0] = 9'b111;
        poly_v[1] = 9'b101;
        set_cfg(1'b0, 2'b00, poly_v, 4);
        push_frame_a();
        d0 = done_cnt;
        start_frame(1'b0);
        feed_bits(2);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2;
        check("no_done_on_abort", 32'(done_cnt), 32'(d0));
        run_frame_a(0, 1'b0);

        // Randomised frames with random backpressure and enable
        for (int f = 0; f < 14; f++) begin
            mode = (f % 2 == 0) ? 1 : 3;
            len  = $urandom_range(1, 40);
            rate = 1'($urandom);
            kl   = 2'($urandom);
            poly_v = {9'($urandom), 9'($urandom), 9'($urandom)};
            for (int b = 0; b < len; b++) frame_bits[b] = 1'($urandom);
            set_cfg(rate, kl, poly_v, len);
            model_push(rate, kl, poly_v, len);
            d0 = done_cnt;
            start_frame(f % 3 == 0);
            feed_bits(len);
            i_start = 1'b0;
            wait_done(d0);
        end

        mode = 0;
        repeat (2) @(posedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
